// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the Execute-stage multiply/divide unit:
// opcode/funct7 constants, funct3 operation encodings, FSM states and
// the funct3-driven result selector used by both the iterative and the
// single-cycle paths.
package riscv_pkg;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // Pick the architectural result out of the sign-corrected product,
    // quotient and remainder according to the operation.
    function automatic logic [31:0] select_result(
        input muldiv_op_t  op,
        input logic [63:0] prod,
        input logic [31:0] quo,
        input logic [31:0] rem
    );
        case (op)
            OP_MUL:                       return prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[63:32];
            OP_DIV, OP_DIVU:              return quo;
            default:                      return rem;
        endcase
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-division datapath for the multiply/divide unit. Works on
// operand magnitudes, producing one quotient bit per step. It also owns
// the iteration counter, which the top reuses to time the multiply path.
// The next-step quotient and remainder are exported combinationally so
// the top can capture the final result on the last iteration.
module mdu_div_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo_next,
    output logic [XLEN-1:0] o_rem_next,
    output logic            o_last
);

    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_divisor;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic             w_qbit;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the trial subtraction only if it did not borrow.
    always_comb begin
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_divisor};
        w_qbit     = ~w_diff[XLEN];
        o_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        o_quo_next = {r_quo[XLEN-2:0], w_qbit};
        o_last     = (r_cnt == {CNT_W{1'b1}});
    end

    // Load magnitudes at start, then advance one quotient bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_quo     <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_cnt     <= '0;
        end else if (i_step) begin
            r_quo     <= o_quo_next;
            r_rem     <= o_rem_next;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit living in the Execute stage.
// Multiplies use a radix-2 shift-add loop and divides use restoring
// division (mdu_div_core), both 32 iterations on operand magnitudes with
// the sign fixed up as the result is captured. Divide-by-zero and signed
// overflow are resolved immediately at start.
// Build option MULDIV_FAST_MUL_EN: multiplies complete through a
// single-cycle combinational product instead of the iterative loop.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [6:0]      instr_opcodeE,
    input  logic [2:0]      funct3E,
    input  logic [6:0]      funct7E,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_t        r_state;
    mdu_state_t        w_next_state;
    muldiv_op_t        r_funct3;
    logic              r_neg_prod;
    logic              r_neg_a;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_prod;

    logic              w_start;
    logic              w_is_div;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic              w_direct;
    logic              w_step;
    logic              w_last;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;
    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_prod_step;
    logic [2*XLEN-1:0] w_prod_fix;

    // Decode the EX instruction: start condition, operand signedness,
    // magnitudes and the divide corner cases that bypass the loop.
    always_comb begin
        w_start    = valid_i & ~flush_i & (instr_opcodeE == OPCODE_R)
                   & (funct7E == FUNCT7_MULDIV) & (r_state == IDLE);
        w_is_div   = funct3E[2];
        w_sign_a   = (funct3E == OP_MULH) | (funct3E == OP_MULHSU)
                   | (funct3E == OP_DIV)  | (funct3E == OP_REM);
        w_sign_b   = (funct3E == OP_MULH) | (funct3E == OP_DIV)
                   | (funct3E == OP_REM);
        w_neg_a    = w_sign_a & op_a[XLEN-1];
        w_neg_b    = w_sign_b & op_b[XLEN-1];
        w_abs_a    = w_neg_a ? -op_a : op_a;
        w_abs_b    = w_neg_b ? -op_b : op_b;
        w_div_zero = w_is_div & (op_b == '0);
        w_div_ovf  = w_is_div & ~funct3E[0]
                   & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        w_special  = w_div_zero | w_div_ovf;
        if (w_div_zero) begin
            w_special_result = select_result(muldiv_op_t'(funct3E), '0, '1, op_a);
        end else begin
            w_special_result = select_result(muldiv_op_t'(funct3E), '0,
                                             {1'b1, {(XLEN-1){1'b0}}}, '0);
        end
`ifdef MULDIV_FAST_MUL_EN
        w_direct   = w_special | ~w_is_div;
`else
        w_direct   = w_special;
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;

    // Single-cycle product of the sign-extended operands (33x33 signed).
    always_comb begin
        w_fast_prod = {{XLEN{w_neg_a}}, op_a} * {{XLEN{w_neg_b}}, op_b};
    end
`endif

    // One shift-add multiply step plus the sign fix-up applied as the
    // final iteration's result is captured.
    always_comb begin
        w_add       = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_step = {w_add, r_prod[XLEN-1:1]};
        w_prod_fix  = r_neg_prod ? -w_prod_step : w_prod_step;
        w_quo_fix   = r_neg_prod ? -w_quo_next : w_quo_next;
        w_rem_fix   = r_neg_a ? -w_rem_next : w_rem_next;
        w_final     = select_result(r_funct3, w_prod_fix, w_quo_fix, w_rem_fix);
        w_step      = (r_state == BUSY) & ~flush_i;
    end

    mdu_div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start),
        .i_step     (w_step),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quo_next (w_quo_next),
        .o_rem_next (w_rem_next),
        .o_last     (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and pipeline handshake outputs; flush always wins.
    always_comb begin
        w_next_state = r_state;
        stall_o      = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            IDLE:    if (w_start) w_next_state = w_direct ? DONE : BUSY;
            BUSY:    if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (flush_i) begin
            w_next_state = IDLE;
        end
        stall_o = w_start | (r_state == BUSY);
        busy_o  = (r_state != IDLE);
        done_o  = (r_state == DONE) & ~flush_i;
        if (rst) begin
            stall_o = 1'b0;
            busy_o  = 1'b0;
            done_o  = 1'b0;
        end
    end

    // Operand/sign capture at start, multiply accumulation while BUSY and
    // result capture on entry to DONE; the result holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3   <= OP_MUL;
            r_neg_prod <= 1'b0;
            r_neg_a    <= 1'b0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_result   <= '0;
        end else if (w_start) begin
            r_funct3   <= muldiv_op_t'(funct3E);
            r_neg_prod <= w_neg_a ^ w_neg_b;
            r_neg_a    <= w_neg_a;
            r_mcand    <= w_abs_a;
            r_prod     <= {{XLEN{1'b0}}, w_abs_b};
            if (w_special) begin
                r_result <= w_special_result;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!w_is_div) begin
                r_result <= select_result(muldiv_op_t'(funct3E), w_fast_prod, '0, '0);
            end
`endif
        end else if (w_step) begin
            r_prod <= w_prod_step;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (default build). Expected
// results are pushed to a scoreboard queue as each operation is driven
// and popped when done_o reports the result.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        flush_i;
    logic [6:0]  instr_opcodeE;
    logic [2:0]  funct3E;
    logic [6:0]  funct7E;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] result;
        int          stalls;
        string       name;
    } expItem_t;

    expItem_t    expQ[$];
    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] lastResult = 32'h0;

    ex_muldiv_unit dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .flush_i       (flush_i),
        .instr_opcodeE (instr_opcodeE),
        .funct3E       (funct3E),
        .funct7E       (funct7E),
        .op_a          (op_a),
        .op_b          (op_b),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something blocks the main sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one M-op from the next falling edge and wait for done_o,
    // counting stall cycles; the instruction leaves EX after DONE.
    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int stalls, output bit gotDone);
        @(negedge clk);
        valid_i       = 1'b1;
        flush_i       = 1'b0;
        instr_opcodeE = OPCODE_R;
        funct7E       = FUNCT7_MULDIV;
        funct3E       = f3;
        op_a          = a;
        op_b          = b;
        stalls        = 0;
        gotDone       = 1'b0;
        res           = 32'h0;
        for (int i = 0; i < 200 && !gotDone; i++) begin
            #1;
            if (done_o) begin
                gotDone = 1'b1;
                res     = result_o;
            end else begin
                if (stall_o) stalls++;
                @(negedge clk);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        valid_i = 1'b1; instr_opcodeE = OPCODE_R; funct7E = FUNCT7_MULDIV;
        funct3E = 3'b000; op_a = 32'd3; op_b = 32'd5;
        #1;
        checkCount++;
        if (stall_o !== 1'b0) begin
            errorCount++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o);
        end
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b0;
        #1;
        checkCount++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_ctrl: got busy=%b done=%b stall=%b expected 0 0 0", busy_o, done_o, stall_o);
        end
        checkCount++;
        if (result_o !== 32'h0) begin
            errorCount++; $display("[TB] FAIL reset_result: got %h expected 00000000", result_o);
        end
    endtask

    task automatic test_mul();
        logic [31:0] res; int stalls; bit gotDone; expItem_t item;
        expQ.push_back('{32'hFFFFFFEB, 33, "MUL_7_m3"});
        runOp(3'b000, 32'd7, 32'hFFFFFFFD, res, stalls, gotDone);
        item = expQ.pop_front();
        checkCount++;
        if (!gotDone) begin
            errorCount++; $display("[TB] FAIL %s done: got none expected pulse", item.name);
        end else if (res !== item.result) begin
            errorCount++; $display("[TB] FAIL %s result: got %h expected %h", item.name, res, item.result);
        end
        checkCount++;
        if (stalls !== item.stalls) begin
            errorCount++; $display("[TB] FAIL %s stalls: got %0d expected %0d", item.name, stalls, item.stalls);
        end
        lastResult = item.result;
        @(negedge clk); #1;
        checkCount++;
        if (done_o !== 1'b0 || stall_o !== 1'b0 || busy_o !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL MUL_pulse: got done=%b stall=%b busy=%b expected 0 0 0", done_o, stall_o, busy_o);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [3]  = '{3'b011, 3'b001, 3'b010};
        logic [31:0] exps [3] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
        string       names [3] = '{"MULHU", "MULH", "MULHSU"};
        logic [31:0] res; int stalls; bit gotDone; expItem_t item;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back('{exps[i], 33, names[i]});
            runOp(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, res, stalls, gotDone);
            item = expQ.pop_front();
            checkCount++;
            if (!gotDone) begin
                errorCount++; $display("[TB] FAIL %s done: got none expected pulse", item.name);
            end else if (res !== item.result) begin
                errorCount++; $display("[TB] FAIL %s result: got %h expected %h", item.name, res, item.result);
            end
            checkCount++;
            if (stalls !== item.stalls) begin
                errorCount++; $display("[TB] FAIL %s stalls: got %0d expected %0d", item.name, stalls, item.stalls);
            end
            lastResult = item.result;
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as [4]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs [4]   = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        string       names [4] = '{"DIV_m7_2", "REM_m7_2", "DIVU_100_7", "REMU_100_7"};
        logic [31:0] res; int stalls; bit gotDone; expItem_t item;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back('{exps[i], 33, names[i]});
            runOp(ops[i], as[i], bs[i], res, stalls, gotDone);
            item = expQ.pop_front();
            checkCount++;
            if (!gotDone) begin
                errorCount++; $display("[TB] FAIL %s done: got none expected pulse", item.name);
            end else if (res !== item.result) begin
                errorCount++; $display("[TB] FAIL %s result: got %h expected %h", item.name, res, item.result);
            end
            checkCount++;
            if (stalls !== item.stalls) begin
                errorCount++; $display("[TB] FAIL %s stalls: got %0d expected %0d", item.name, stalls, item.stalls);
            end
            lastResult = item.result;
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4]  = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as [4]   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs [4]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        string       names [4] = '{"DIVU_5_0", "REM_5_0", "DIV_ovf", "REM_ovf"};
        logic [31:0] res; int stalls; bit gotDone; expItem_t item;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back('{exps[i], 1, names[i]});
            runOp(ops[i], as[i], bs[i], res, stalls, gotDone);
            item = expQ.pop_front();
            checkCount++;
            if (!gotDone) begin
                errorCount++; $display("[TB] FAIL %s done: got none expected pulse", item.name);
            end else if (res !== item.result) begin
                errorCount++; $display("[TB] FAIL %s result: got %h expected %h", item.name, res, item.result);
            end
            checkCount++;
            if (stalls !== item.stalls) begin
                errorCount++; $display("[TB] FAIL %s stalls: got %0d expected %0d", item.name, stalls, item.stalls);
            end
            lastResult = item.result;
        end
    endtask

    task automatic test_nonmop();
        logic       vals [3] = '{1'b1, 1'b0, 1'b1};
        logic [6:0] opcs [3] = '{OPCODE_R, OPCODE_R, 7'b0111011};
        logic [6:0] f7s [3]  = '{7'b0000000, FUNCT7_MULDIV, FUNCT7_MULDIV};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_i = vals[i]; instr_opcodeE = opcs[i]; funct7E = f7s[i];
            funct3E = 3'b100; op_a = 32'd50; op_b = 32'd5;
            #1;
            checkCount++;
            if (stall_o !== 1'b0) begin
                errorCount++; $display("[TB] FAIL nonmop%0d_stall: got %b expected 0", i, stall_o);
            end
            @(negedge clk); #1;
            checkCount++;
            if (busy_o !== 1'b0 || result_o !== lastResult) begin
                errorCount++;
                $display("[TB] FAIL nonmop%0d_hold: got busy=%b result=%h expected 0 %h", i, busy_o, result_o, lastResult);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res; int stalls; bit gotDone; expItem_t item; int doneSeen;
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b0; instr_opcodeE = OPCODE_R; funct7E = FUNCT7_MULDIV;
        funct3E = 3'b000; op_a = 32'd5; op_b = 32'd6;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        checkCount++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_idle: got busy=%b stall=%b done=%b expected 0 0 0", busy_o, stall_o, done_o);
        end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_o) doneSeen++;
        end
        checkCount++;
        if (doneSeen !== 0 || result_o !== lastResult) begin
            errorCount++;
            $display("[TB] FAIL flush_nodone: got pulses=%0d result=%h expected 0 %h", doneSeen, result_o, lastResult);
        end
        expQ.push_back('{32'd12, 33, "MUL_3_4"});
        runOp(3'b000, 32'd3, 32'd4, res, stalls, gotDone);
        item = expQ.pop_front();
        checkCount++;
        if (!gotDone) begin
            errorCount++; $display("[TB] FAIL %s done: got none expected pulse", item.name);
        end else if (res !== item.result) begin
            errorCount++; $display("[TB] FAIL %s result: got %h expected %h", item.name, res, item.result);
        end
        checkCount++;
        if (stalls !== item.stalls) begin
            errorCount++; $display("[TB] FAIL %s stalls: got %0d expected %0d", item.name, stalls, item.stalls);
        end
        lastResult = item.result;
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        @(negedge clk);
        valid_i = 1'b1; instr_opcodeE = OPCODE_R; funct7E = FUNCT7_MULDIV;
        funct3E = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        repeat (6) @(negedge clk);
        rst = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkCount++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_state: got busy=%b stall=%b result=%h expected 0 0 00000000", busy_o, stall_o, result_o);
        end
        lastResult = 32'h0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_o) doneSeen++;
        end
        checkCount++;
        if (doneSeen !== 0) begin
            errorCount++; $display("[TB] FAIL rstmid_nodone: got %0d pulses expected 0", doneSeen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int stalls; bit gotDone; expItem_t item; int doneCount;
        logic [2:0]  ops [2] = '{3'b101, 3'b000};
        logic [31:0] as [2]  = '{32'd9, 32'd2};
        logic [31:0] bs [2]  = '{32'd3, 32'd2};
        doneCount = 0;
        expQ.push_back('{32'd3, 33, "B2B_DIVU_9_3"});
        expQ.push_back('{32'd4, 33, "B2B_MUL_2_2"});
        for (int i = 0; i < 2; i++) begin
            runOp(ops[i], as[i], bs[i], res, stalls, gotDone);
            item = expQ.pop_front();
            if (gotDone) doneCount++;
            checkCount++;
            if (!gotDone) begin
                errorCount++; $display("[TB] FAIL %s done: got none expected pulse", item.name);
            end else if (res !== item.result) begin
                errorCount++; $display("[TB] FAIL %s result: got %h expected %h", item.name, res, item.result);
            end
            checkCount++;
            if (stalls !== item.stalls) begin
                errorCount++; $display("[TB] FAIL %s stalls: got %0d expected %0d", item.name, stalls, item.stalls);
            end
            lastResult = item.result;
        end
        checkCount++;
        if (doneCount !== 2 || expQ.size() !== 0) begin
            errorCount++;
            $display("[TB] FAIL b2b_pulses: got %0d pulses, %0d pending expected 2, 0", doneCount, expQ.size());
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        instr_opcodeE = 7'h0; funct3E = 3'h0; funct7E = 7'h0;
        op_a = 32'h0; op_b = 32'h0;
        $display("[TB] starting ex_muldiv_unit bench");
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_nonmop();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage. It sits directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage opcode, funct3 and funct7, plus the forwarded operands A and B.
- Freezes the front of the pipeline via stall_o until the result is ready. result_o then feeds the EX/MEM register through the ALU-result mux.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; equals log2(XLEN).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  EX holds a real instruction (0 = bubble)
- flush_i  in  1  kill the EX instruction (branch/jump taken)
- instr_opcodeE  in  7  opcode of the EX instruction
- funct3E  in  3  operation select
- funct7E  in  7  0000001 marks an M-extension operation
- op_a  in  32  forwarded rs1 value
- op_b  in  32  forwarded rs2 value
- stall_o  out  1  freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM
- busy_o  out  1  FSM is not IDLE
- done_o  out  1  result_o is valid this cycle
- result_o  out  32  M-extension result

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, cnt=0, result_o=0, done_o=0. stall_o and busy_o are forced to 0 while rst is high. Reset mid-operation abandons the operation; no done_o is produced.
- Start condition: start = valid_i & !flush_i & opcode==0110011 & funct7==0000001 & state==IDLE.
- stall_o = start | (state==BUSY). It is combinational, so the pipeline freezes in the start cycle itself.
- At start, latch the following:
  - |op_a| and |op_b|, per signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats only A as signed; MULHU/DIVU/REMU treat both as unsigned.
  - the result-sign flags and funct3.
- States:
  - IDLE -> BUSY on start.
  - IDLE -> DONE on start if a special divide case applies (see below).
  - BUSY -> DONE when cnt==31.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on flush_i, with no done_o.
- BUSY, multiply: radix-2 shift-add, one bit per cycle, 32 cycles, into a 64-bit accumulator.
- BUSY, divide: restoring division, one quotient bit per cycle, 32 cycles.
- DONE: done_o=1 and result_o is valid; stall_o=0, so the pipeline advances and EX/MEM captures result_o. DONE never restarts, even though the same instruction is still visible at the inputs.
- Latency: normal operation stalls for 33 cycles (start + 32 BUSY); the result appears in the 34th cycle.
- Back-to-back M-ops: the second op enters EX in the cycle after DONE and starts from IDLE.
- Result selection by funct3:
  - 000 MUL = product[31:0]
  - 001 MULH = product[63:32]
  - 010 MULHSU = product[63:32]
  - 011 MULHU = product[63:32]
  - 100 DIV = quotient
  - 101 DIVU = quotient
  - 110 REM = remainder
  - 111 REMU = remainder
- Sign fix-up happens on entry to DONE:
  - the 64-bit product is negated if the operand signs differ;
  - the quotient is negated if the signs differ;
  - the remainder takes the sign of the dividend.
- Special divide cases are detected at start and take IDLE -> DONE, giving 1 stall cycle:
  - divisor==0: quotient=0xFFFFFFFF, remainder=op_a.
  - signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- When valid_i=0 or the op is not an M-op, the FSM stays in IDLE with stall_o=0. result_o holds its last value.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: multiplies use a single-cycle combinational 33x33 signed product. Flow is IDLE -> DONE with 1 stall cycle; divides are unchanged.
- Undefined: multiplies use the iterative 32-cycle path described above.

Decomposition:
- Shared package riscv_pkg holds:
  - OPCODE_R = 7'b0110011
  - FUNCT7_MULDIV = 7'b0000001
  - muldiv_op_t enum for the 8 funct3 encodings
  - mdu_state_t {IDLE, BUSY, DONE}
- Natural sub-module: mdu_div_core, the restoring-division datapath plus counter. The multiply path and the FSM stay in the top.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> stall_o high for 33 cycles; done_o pulses for 1 cycle; result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU with the same operands -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Each gives 1 stall cycle followed by done_o.
- Flush at BUSY iteration 10 -> IDLE the next cycle, stall_o=0, no done_o; a following MUL 3*4 -> 12 with full latency.
- rst asserted mid-divide -> the following cycle shows busy_o=0, stall_o=0, result_o=0; back-to-back DIVU 9/3 then MUL 2*2 -> 3 and 4, with two separate done_o pulses.
